fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- UART transmitter that drains the SoC's synchronous TX FIFO (registered read data, one-cycle read latency) and serialises its contents onto a single 8N1 line.
- Sits between the PicoRV32 memory-mapped UART write path, which fills the FIFO, and the board TX pin.
- Each FIFO word is sent as BYTES_PER_WORD bytes, least-significant byte first.

Parameters:
- FIFO_WIDTH, 32, width of the FIFO read-data bus.
- BYTES_PER_WORD, 1, bytes sent per popped word (1..4); uses fifo_data[8*BYTES_PER_WORD-1:0].
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  allow new FIFO words to be fetched.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  FIFO_WIDTH  FIFO registered read data; valid the cycle after a pop.
- fifo_rd_en  out  1  FIFO pop request; one-cycle pulse.
- tx  out  1  serial line; idle high.
- busy  out  1  high whenever state is not IDLE.
- byte_done  out  1  one-cycle pulse on the last clk of each stop bit.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; tx=1; fifo_rd_en=0; busy=0; byte_done=0.
  - Baud counter, bit index and byte index cleared; shift register cleared.
  - A word in flight is lost; the FIFO is not re-read.
- All outputs are registered or Moore-decoded from state; no combinational path from inputs to outputs.
- States: IDLE, REQ, WAIT, START, DATA, STOP (plus PARITY under the macro).
- IDLE: tx=1. Moves to REQ when enable=1 and fifo_empty=0 are sampled.
- REQ: fifo_rd_en=1 for exactly this one cycle, then WAIT. Never pops when fifo_empty=1.
- WAIT: fifo_data is valid this cycle. Latch the word into the shift register, byte index=0, then START.
- Latency: if enable & !fifo_empty are sampled in IDLE at edge N, tx falls at edge N+3.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, LSB first; each bit held exactly CLKS_PER_BIT cycles.
  - Bit index 0..7; after bit 7 go to STOP (or PARITY).
- STOP:
  - tx=1 for CLKS_PER_BIT cycles; byte_done pulses on the final cycle.
  - Then, if byte index < BYTES_PER_WORD-1: increment byte index, shift the word right by 8, go to START (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and resets to 0 on every bit transition.
  - Width $clog2(CLKS_PER_BIT); no wrap beyond CLKS_PER_BIT-1.
- Frame length: 10*CLKS_PER_BIT cycles (11* with parity). Minimum inter-word gap is 3 idle-high cycles (STOP->IDLE->REQ->WAIT).
- enable deasserted mid-word: all remaining bytes of the current word still complete; no new pop; then stay in IDLE.
- fifo_empty changes outside IDLE: ignored.
- fifo_data is sampled only in WAIT.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined: a PARITY state between DATA and STOP. tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11 bits.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP. Frame = 10 bits.

Test Plan:
- Reset: CLKS_PER_BIT=4, drive reset_n=0 mid-DATA -> tx=1, busy=0, fifo_rd_en=0 immediately; after release, no pop while fifo_empty=1.
- Single byte: FIFO holds 0x000000A5 -> exactly one fifo_rd_en pulse; tx falls 3 cycles later.
  - tx bits 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each 4 cycles.
  - byte_done one pulse; back to IDLE.
- Multi-byte: BYTES_PER_WORD=4, word 0x44332211 -> bytes 0x11,0x22,0x33,0x44 back-to-back, no idle gap between frames; one pop; four byte_done pulses.
- Streaming: FIFO holds 3 words -> 3 pops, each pop only after the previous word's last stop bit; 3-cycle idle-high gap between words; never pop when fifo_empty=1.
- Enable gating: enable=0 with FIFO non-empty -> no pop, tx=1. Drop enable mid-frame -> current word completes, then no further pops.
- Parity (macro defined): byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0; frame 11*CLKS_PER_BIT cycles.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a registered-read TX FIFO onto an 8N1 UART line, LSB byte first; define FIFO_UART_TX_PARITY_EN to add an even-parity bit
module fifo_uart_tx #(
    parameter int FIFO_WIDTH     = 32,
    parameter int BYTES_PER_WORD = 1,
    parameter int CLKS_PER_BIT   = 868
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int SW = 8 * BYTES_PER_WORD;
`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_STOP} state_t;
`endif
    state_t        r_state, w_next;
    logic [CW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [1:0]    r_byte;
    logic [SW-1:0] r_shift;
    logic          r_tx, r_byte_done;
    logic          w_bit_end, w_more, w_unused;
    assign w_bit_end  = r_baud == CW'(CLKS_PER_BIT - 1);
    assign w_more     = r_byte != 2'(BYTES_PER_WORD - 1);
    assign w_unused   = &{1'b0, fifo_data};
    assign fifo_rd_en = r_state == S_REQ;
    assign busy       = r_state != S_IDLE;
    assign tx         = r_tx;
    assign byte_done  = r_byte_done;
    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end
    // next-state: fetch handshake, then start/data/stop bits per byte
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = (enable && !fifo_empty) ? S_REQ : S_IDLE;
            S_REQ:    w_next = S_WAIT;
            S_WAIT:   w_next = S_START;
            S_START:  w_next = w_bit_end ? S_DATA : S_START;
`ifdef FIFO_UART_TX_PARITY_EN
            S_DATA:   w_next = (w_bit_end && r_bit == 3'd7) ? S_PARITY : S_DATA;
            S_PARITY: w_next = w_bit_end ? S_STOP : S_PARITY;
`else
            S_DATA:   w_next = (w_bit_end && r_bit == 3'd7) ? S_STOP : S_DATA;
`endif
            S_STOP:   w_next = !w_bit_end ? S_STOP : w_more ? S_START : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end
    // baud counter, bit/byte indices and word shift register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_shift <= '0;
        end else begin
            r_baud  <= (r_state inside {S_IDLE, S_REQ, S_WAIT} || w_bit_end) ? '0 : r_baud + 1'b1;
            r_bit   <= (r_state == S_DATA) ? r_bit + 3'(w_bit_end) : 3'd0;
            r_byte  <= (r_state == S_WAIT) ? 2'd0 : (r_state == S_STOP && w_bit_end && w_more) ? r_byte + 2'd1 : r_byte;
            r_shift <= (r_state == S_WAIT) ? fifo_data[SW-1:0] : (r_state == S_STOP && w_bit_end && w_more) ? r_shift >> 8 : r_shift;
        end
    end
    // registered line and byte_done so outputs never glitch with state decode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx        <= 1'b1;
            r_byte_done <= 1'b0;
        end else begin
`ifdef FIFO_UART_TX_PARITY_EN
            r_tx        <= (r_state == S_START) ? 1'b0 : (r_state == S_DATA) ? r_shift[r_bit] : (r_state == S_PARITY) ? ^r_shift[7:0] : 1'b1;
`else
            r_tx        <= (r_state == S_START) ? 1'b0 : (r_state == S_DATA) ? r_shift[r_bit] : 1'b1;
`endif
            r_byte_done <= r_state == S_STOP && w_bit_end;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: random stimulus on 1-byte and 4-byte instances, checked every cycle against a line-timing model
module tb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    logic        clk = 0, reset_n = 0, enable = 0;
    logic [31:0] data [2];
    logic        empty [2], rd_en [2], tx [2], busy [2], bd [2];
    logic [31:0] mem0 [$], mem1 [$];
    int          rp [2] = '{0, 0};
    int          npop [2] = '{0, 0};
    int          checks = 0, errors = 0, cyc = 0;
    int          m_pop [2] = '{-1, -1};
    logic [31:0] m_word [2];
    bit          m_req [2] = '{0, 0};

    fifo_uart_tx #(.FIFO_WIDTH(32), .BYTES_PER_WORD(1), .CLKS_PER_BIT(CPB)) u0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(empty[0]), .fifo_data(data[0]),
        .fifo_rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0]), .byte_done(bd[0]));
    fifo_uart_tx #(.FIFO_WIDTH(32), .BYTES_PER_WORD(4), .CLKS_PER_BIT(CPB)) u1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(empty[1]), .fifo_data(data[1]),
        .fifo_rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1]), .byte_done(bd[1]));

    always #5 clk = ~clk;

    assign empty[0] = rp[0] == mem0.size();
    assign empty[1] = rp[1] == mem1.size();

    // synchronous FIFO with one-cycle registered read data
    always @(posedge clk) begin
        if (rd_en[0] && !empty[0]) begin data[0] <= mem0[rp[0]]; rp[0] <= rp[0] + 1; end
        if (rd_en[1] && !empty[1]) begin data[1] <= mem1[rp[1]]; rp[1] <= rp[1] + 1; end
        if (rd_en[0]) npop[0] <= npop[0] + 1;
        if (rd_en[1]) npop[1] <= npop[1] + 1;
    end

    function automatic int nb(input int k);
        return (k != 0) ? 4 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // reference: a pop at cycle c puts frame j bit b on the line at cycle c+3+CPB*(FB*j+b)
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            int d, e, j, b, len;
            logic et, eb, ebusy;
            logic [7:0] bt;
            if (!reset_n) begin m_pop[k] = -1; m_req[k] = 0; end
            if (m_req[k]) begin
                m_pop[k] = cyc;
                m_word[k] = (k != 0) ? mem1[rp[1]] : mem0[rp[0]];
            end
            len = FB * CPB * nb(k);
            d = cyc - m_pop[k];
            et = 1;
            eb = 0;
            ebusy = m_pop[k] >= 0 && d < len + 2;
            if (m_pop[k] >= 0 && d >= 3 && d < len + 3) begin
                e = d - 3;
                j = e / (FB * CPB);
                b = (e % (FB * CPB)) / CPB;
                bt = 8'(m_word[k] >> (8 * j));
                et = (b == 0) ? 1'b0 : (b <= 8) ? bt[3'(b - 1)] : (b == FB - 1) ? 1'b1 : ^bt;
                eb = (e % (FB * CPB)) == FB * CPB - 1;
            end
            chk($sformatf("rd_en%0d", k), rd_en[k], m_req[k]);
            chk($sformatf("tx%0d", k), tx[k], et);
            chk($sformatf("busy%0d", k), busy[k], ebusy);
            chk($sformatf("byte_done%0d", k), bd[k], eb);
            m_req[k] = reset_n && !ebusy && enable && !empty[k];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic [31:0] w0, input logic [31:0] w1);
        mem0.push_back(w0);
        mem1.push_back(w1);
    endtask

    function automatic bit idle_k(input int k);
        int left = (k != 0) ? mem1.size() - rp[1] : mem0.size() - rp[0];
        return !m_req[k] && (m_pop[k] < 0 || cyc - m_pop[k] >= FB * CPB * nb(k) + 2) && (left == 0 || !enable);
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!(idle_k(0) && idle_k(1)) && n < 5000) begin tick(1); n++; end
        chk("drain_timeout", n < 5000, 1);
        tick(4);
    endtask

    initial begin
        tick(3);
        for (int k = 0; k < 2; k++) begin
            chk("rst_tx", tx[k], 1);
            chk("rst_busy", busy[k], 0);
            chk("rst_rd_en", rd_en[k], 0);
            chk("rst_byte_done", bd[k], 0);
        end
        reset_n = 1;
        enable = 1;
        tick(5);
        push2(32'h0000_00A5, 32'h4433_2211);
        wait_idle();
        push2(32'h0000_0007, 32'h0307_0307);
        push2(32'h0000_0003, 32'h0703_0703);
        wait_idle();
        for (int i = 0; i < 3; i++) push2($urandom, $urandom);
        wait_idle();
        enable = 0;
        push2($urandom, $urandom);
        push2($urandom, $urandom);
        tick(60);
        chk("gate_tx0", tx[0], 1);
        chk("gate_left0", mem0.size() - rp[0], 2);
        enable = 1;
        tick(8);
        enable = 0;
        wait_idle();
        tick(40);
        chk("gate_left0", mem0.size() - rp[0], 1);
        chk("gate_left1", mem1.size() - rp[1], 1);
        enable = 1;
        wait_idle();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) push2($urandom, $urandom);
            enable = $urandom_range(0, 4) != 0;
            tick($urandom_range(1, 120));
        end
        enable = 1;
        wait_idle();
        push2(32'h0000_005A, 32'hA1B2_C3D4);
        tick(3 + CPB + 10);
        reset_n = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_tx", tx[k], 1);
            chk("arst_busy", busy[k], 0);
            chk("arst_rd_en", rd_en[k], 0);
        end
        tick(3);
        reset_n = 1;
        tick(40);
        chk("pops0", npop[0], mem0.size());
        chk("pops1", npop[1], mem1.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
